serial_add_sequencer: RTL and testbench

SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

---
 rtl/serial_add_pkg.sv | 10 +
 rtl/serial_fa_cell.sv | 38 +++
 rtl/serial_add_sequencer.sv | 117 +++++++++++
 tb/tb_serial_add_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder: the sequencer FSM state encoding.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with a registered carry, stepped once per enabled cycle.
module serial_fa_cell (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    logic carry_q;
    logic carry_d;

    assign sum   = a ^ b ^ carry_q;
    assign carry = carry_q;

    always_comb begin
        // NOTE: assign the default first so every path drives carry_d and no latch is inferred.
        carry_d = carry_q;
        if (clr) begin
            carry_d = 1'b0;
        end else if (en) begin
            carry_d = (a & b) | (carry_q & (a ^ b));
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so all flops update from pre-edge values.
        if (rst) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial adder: accepts an operand pair, adds LSB-first over WIDTH cycles,
// then presents sum and carry until the consumer takes them.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
);

    // Number of bits needed to hold the value WIDTH, i.e. ceil(log2(WIDTH plus one)).
    localparam int CNT_W = $clog2((WIDTH << 1) | 1) - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // Counter increment built from a prefix-AND of the low bits: bit i toggles
    // when every bit below it is one. Covers counters up to 8 bits.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] x);
        logic [CNT_W-1:0] c;
        c = (x << 1) | CNT_W'(1);
        c = c & ((c << 1) | CNT_W'(1));
        c = c & ((c << 2) | CNT_W'(3));
        c = c & ((c << 4) | CNT_W'(15));
        return x ^ c;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               fa_clr;
    logic               fa_en;
    logic               sum_bit;
    logic               fa_carry;

    serial_fa_cell u_fa (
        .clk   (clk),
        .rst   (rst),
        .clr   (fa_clr),
        .en    (fa_en),
        .a     (a_q[0]),
        .b     (b_q[0]),
        .sum   (sum_bit),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        fa_clr  = 1'b0;
        fa_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    cnt_d   = '0;
                    fa_clr  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fa_en = 1'b1;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {sum_bit, res_q[WIDTH-1:1]};
                cnt_d = cnt_inc(cnt_q);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: data registers are reset too, so the outputs read zero straight after reset.
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign out_sum   = res_q;
    assign out_carry = fa_carry;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer: vector table, corner sequences,
// and a randomized stream scored against an A+B queue model.
module tb_serial_add_sequencer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;
    logic         busy;

    int errors = 0;
    int checks = 0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one operand pair, returns the result and the edge count from accept to out_valid.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit take,
                         output logic [W-1:0] s, output logic c, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        tick();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        s = out_sum;
        c = out_carry;
        if (take) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    task automatic run_stream(input string tag, input int n_ops, input int vpct, input int rpct,
                              input bit check_spacing);
        logic [W:0] exp_q[$];
        logic [W:0] e;
        int accepted = 0;
        int done     = 0;
        int cyc      = 0;
        int last_acc = -1;
        int overlap  = 0;
        int extra    = 0;
        while (done < n_ops && cyc < 60000) begin
            in_valid  = (accepted < n_ops) && ($urandom_range(99) < vpct);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = ($urandom_range(99) < rpct);
            if (in_ready && out_valid) overlap++;
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, in_a} + {1'b0, in_b});
                accepted++;
                if (check_spacing && last_acc >= 0)
                    check({tag, "_spacing"}, 64'(cyc - last_acc), 64'(W + 2));
                last_acc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_result"}, 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_sum"}, 64'(out_sum), 64'(e[W-1:0]));
                    check({tag, "_carry"}, 64'(out_carry), 64'(e[W]));
                end
                done++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            if (out_valid) extra++;
            tick();
        end
        out_ready = 1'b0;
        check({tag, "_results_done"}, 64'(done), 64'(n_ops));
        check({tag, "_left_in_model"}, 64'(exp_q.size()), 64'(0));
        check({tag, "_duplicates"}, 64'(extra), 64'(0));
        check({tag, "_ready_valid_overlap"}, 64'(overlap), 64'(0));
    endtask

    initial begin
        logic [W-1:0] s;
        logic         c;
        int           lat;

        vecs[0] = '{8'h5A, 8'h33, 8'h8D, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b1};
        vecs[3] = '{8'h01, 8'h01, 8'h02, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 8'h80, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_out_sum", 64'(out_sum), 64'(0));
        check("rst_out_carry", 64'(out_carry), 64'(0));
        rst = 1'b0;
        tick();

        // Back-to-back vectors; 0xFF+0x01 then 0x80+0x80 then 0x01+0x01 shows carry clears per op.
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, 1'b1, s, c, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W));
            check($sformatf("vec%0d_sum", i), 64'(s), 64'(vecs[i].sum));
            check($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].carry));
        end

        // Consumer stalls in DONE while the producer keeps poking the input.
        do_op(8'hC3, 8'h5A, 1'b0, s, c, lat);
        check("stall_latency", 64'(lat), 64'(W));
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            in_a     = W'($urandom);
            tick();
            check("stall_sum", 64'(out_sum), 64'(8'h1D));
            check("stall_carry", 64'(out_carry), 64'(1));
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_release_in_ready", 64'(in_ready), 64'(1));
        check("stall_release_out_valid", 64'(out_valid), 64'(0));

        // Reset lands on the third RUN edge of 0xF0+0x0F.
        in_valid = 1'b1;
        in_a     = 8'hF0;
        in_b     = 8'h0F;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("abort_busy_before", 64'(busy), 64'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", 64'(in_ready), 64'(1));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_out_sum", 64'(out_sum), 64'(0));
        check("abort_out_carry", 64'(out_carry), 64'(0));
        do_op(8'h01, 8'h02, 1'b1, s, c, lat);
        check("post_abort_latency", 64'(lat), 64'(W));
        check("post_abort_sum", 64'(s), 64'(8'h03));
        check("post_abort_carry", 64'(c), 64'(0));

        run_stream("full_rate", 6, 100, 100, 1'b1);
        run_stream("random", 1000, 60, 60, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
